// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: downstream control, program-memory port and IF/ID outputs.
// The _i/_o suffixes are named from the fetch unit's point of view.
interface instruction_fetch_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  stall_i;
    logic                  flush_i;
    logic                  pc_src_i;
    logic [DATA_WIDTH-1:0] target_i;
    logic [DATA_WIDTH-1:0] rom_instruction_i;
    logic [DATA_WIDTH-1:0] rom_address_o;
    logic [DATA_WIDTH-1:0] instruction_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] pc_plus4_o;
    logic                  valid_o;
    logic                  fault_o;

    modport master (
        input  stall_i, flush_i, pc_src_i, target_i, rom_instruction_i,
        output rom_address_o, instruction_o, pc_o, pc_plus4_o, valid_o, fault_o
    );

    modport slave (
        output stall_i, flush_i, pc_src_i, target_i, rom_instruction_i,
        input  rom_address_o, instruction_o, pc_o, pc_plus4_o, valid_o, fault_o
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational program ROM and fills the
// IF/ID register; halts with a sticky fault on illegal or out-of-range fetches.
module instruction_fetch_unit #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000,
    parameter int unsigned           MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] NOP          = 32'h0000_0013
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master fetch_if
);

    localparam logic [DATA_WIDTH-1:0] TEXT_END =
        DATA_WIDTH'(TEXT_BASE + DATA_WIDTH'(4 * MEMORY_DEPTH));

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pcOut_q, pcOut_d;
    logic [DATA_WIDTH-1:0] pcPlus4Out_q, pcPlus4Out_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;

    logic [DATA_WIDTH-1:0] pcPlus4;
    logic                  pcAtLastWord;
    logic                  targetLegal;

    assign pcPlus4      = pc_q + DATA_WIDTH'(4);
    assign pcAtLastWord = (pcPlus4 == TEXT_END);
    assign targetLegal  = (fetch_if.target_i[1:0] == 2'b00) &&
                          (fetch_if.target_i >= TEXT_BASE) &&
                          (fetch_if.target_i < TEXT_END);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pcOut_d      = pcOut_q;
        pcPlus4Out_d = pcPlus4Out_q;
        valid_d      = valid_q;
        fault_d      = fault_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (fetch_if.pc_src_i) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    if (targetLegal) begin
                        pc_d = fetch_if.target_i;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                end else if (fetch_if.flush_i) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    // Advancing past the last ROM word would fetch garbage, so halt instead.
                    if (!fetch_if.stall_i) begin
                        if (pcAtLastWord) begin
                            state_d = HALT;
                            fault_d = 1'b1;
                        end else begin
                            pc_d = pcPlus4;
                        end
                    end
                end else if (!fetch_if.stall_i) begin
                    instr_d      = fetch_if.rom_instruction_i;
                    pcOut_d      = pc_q;
                    pcPlus4Out_d = pcPlus4;
                    valid_d      = 1'b1;
                    if (pcAtLastWord) begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = pcPlus4;
                    end
                end
            end
            HALT: begin
                instr_d = NOP;
                valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= TEXT_BASE;
            instr_q      <= NOP;
            pcOut_q      <= '0;
            pcPlus4Out_q <= '0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pcOut_q      <= pcOut_d;
            pcPlus4Out_q <= pcPlus4Out_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
        end
    end

    assign fetch_if.rom_address_o = (pc_q - TEXT_BASE) >> 2;
    assign fetch_if.instruction_o = instr_q;
    assign fetch_if.pc_o          = pcOut_q;
    assign fetch_if.pc_plus4_o    = pcPlus4Out_q;
    assign fetch_if.valid_o       = valid_q;
    assign fetch_if.fault_o       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of instruction_fetch_unit against a word-indexed
// behavioural model of the fetch rules, using a ROM whose word i holds 0x1000_0000+i.
module tb_instruction_fetch_unit;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 64;
    localparam logic [31:0] NOPW  = 32'h0000_0013;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

    instruction_fetch_unit #(
        .DATA_WIDTH  (32),
        .TEXT_BASE   (BASE),
        .MEMORY_DEPTH(DEPTH),
        .NOP         (NOPW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .fetch_if(bus.master)
    );

    always #5 clk = ~clk;

    assign bus.rom_instruction_i = (bus.rom_address_o < 32'(DEPTH)) ?
                                   (32'h1000_0000 + bus.rom_address_o) : 32'hBAD0_BAD0;

    int total = 0;
    int bad   = 0;

    // Model state: word index of the PC plus the visible IF/ID contents.
    bit          mBoot;
    bit          mHalted;
    int          mWord;
    logic [31:0] mInstr;
    logic [31:0] mPcOut;
    logic [31:0] mPlus4;
    logic        mValid;
    logic        mFault;

    function automatic bit legalTarget(input logic [31:0] t);
        longint tl;
        tl = longint'(t);
        return (tl % 4 == 0) && (tl >= longint'(BASE)) && (tl < longint'(BASE) + 4 * DEPTH);
    endfunction

    task automatic modelReset();
        mBoot   = 1'b1;
        mHalted = 1'b0;
        mWord   = 0;
        mInstr  = NOPW;
        mPcOut  = 32'h0;
        mPlus4  = 32'h0;
        mValid  = 1'b0;
        mFault  = 1'b0;
    endtask

    task automatic modelBubble();
        mInstr = NOPW;
        mValid = 1'b0;
    endtask

    task automatic modelHalt();
        mHalted = 1'b1;
        mFault  = 1'b1;
    endtask

    task automatic modelEdge(input bit s, input bit f, input bit p, input logic [31:0] t);
        if (mBoot) begin
            mBoot = 1'b0;
        end else if (mHalted) begin
            modelBubble();
        end else if (p) begin
            modelBubble();
            if (legalTarget(t)) mWord = int'((t - BASE) / 4);
            else modelHalt();
        end else if (f) begin
            modelBubble();
            if (!s) begin
                if (mWord == DEPTH - 1) modelHalt();
                else mWord = mWord + 1;
            end
        end else if (!s) begin
            mInstr = 32'h1000_0000 + 32'(mWord);
            mPcOut = BASE + 32'(4 * mWord);
            mPlus4 = mPcOut + 32'd4;
            mValid = 1'b1;
            if (mWord == DEPTH - 1) modelHalt();
            else mWord = mWord + 1;
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".instr"}, bus.instruction_o, mInstr);
        checkValue({tag, ".pc"}, bus.pc_o, mPcOut);
        checkValue({tag, ".pc4"}, bus.pc_plus4_o, mPlus4);
        checkValue({tag, ".valid"}, 32'(bus.valid_o), 32'(mValid));
        checkValue({tag, ".fault"}, 32'(bus.fault_o), 32'(mFault));
        checkValue({tag, ".romaddr"}, bus.rom_address_o, 32'(mWord));
    endtask

    // Drive one cycle's inputs, advance the model and the DUT by one rising edge.
    task automatic applyStimulus(input bit s, input bit f, input bit p, input logic [31:0] t);
        bus.stall_i  = s;
        bus.flush_i  = f;
        bus.pc_src_i = p;
        bus.target_i = t;
        modelEdge(s, f, p, t);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput(tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit          s, f, p;
        logic [31:0] t;
        int          r;

        bus.stall_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.pc_src_i = 1'b0;
        bus.target_i = 32'h0;
        #1;
        doReset("reset0");

        // Boot sequence.
        applyStimulus(1, 1, 1, 32'h0);
        checkOutput("boot_e1");
        checkValue("boot_e1_valid", 32'(bus.valid_o), 32'd0);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("boot_e2");
        checkValue("boot_e2_instr", bus.instruction_o, 32'h1000_0000);
        checkValue("boot_e2_pc", bus.pc_o, 32'h0040_0000);
        checkValue("boot_e2_pc4", bus.pc_plus4_o, 32'h0040_0004);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("boot_e3");
        checkValue("boot_e3_instr", bus.instruction_o, 32'h1000_0001);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("pre_stall");
        checkValue("pre_stall_pc", bus.pc_o, 32'h0040_0008);

        // Stall for three cycles, then resume.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 32'h0);
            checkOutput("stall");
            checkValue("stall_pc", bus.pc_o, 32'h0040_0008);
            checkValue("stall_romaddr", bus.rom_address_o, 32'd3);
        end
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("stall_release");
        checkValue("stall_release_instr", bus.instruction_o, 32'h1000_0003);

        // Redirect overriding a stall.
        applyStimulus(1, 0, 1, 32'h0040_0020);
        checkOutput("redirect");
        checkValue("redirect_valid", 32'(bus.valid_o), 32'd0);
        checkValue("redirect_instr", bus.instruction_o, NOPW);
        checkValue("redirect_romaddr", bus.rom_address_o, 32'd8);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("redirect_tgt");
        checkValue("redirect_tgt_instr", bus.instruction_o, 32'h1000_0008);

        // Single-cycle flush.
        applyStimulus(0, 1, 0, 32'h0);
        checkOutput("flush");
        checkValue("flush_instr", bus.instruction_o, NOPW);
        checkValue("flush_romaddr", bus.rom_address_o, 32'd10);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("flush_after");
        checkValue("flush_after_pc", bus.pc_o, 32'h0040_0028);

        // Fault A: misaligned target.
        applyStimulus(0, 0, 1, 32'h0040_0002);
        checkOutput("faultA");
        checkValue("faultA_fault", 32'(bus.fault_o), 32'd1);
        checkValue("faultA_romaddr", bus.rom_address_o, 32'd11);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 32'h0040_0010);
            checkOutput("faultA_hold");
            checkValue("faultA_hold_romaddr", bus.rom_address_o, 32'd11);
        end

        // Reset between edges while faulted.
        @(negedge clk);
        doReset("midreset");
        checkValue("midreset_fault", 32'(bus.fault_o), 32'd0);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("midreset_boot1");
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("midreset_boot2");
        checkValue("midreset_boot2_pc", bus.pc_o, BASE);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("faultB_pre");

        // Fault B: target one past the end of the ROM.
        applyStimulus(0, 0, 1, 32'h0040_0100);
        checkOutput("faultB");
        checkValue("faultB_fault", 32'(bus.fault_o), 32'd1);
        checkValue("faultB_romaddr", bus.rom_address_o, 32'd2);

        // Fault C: sequential run off the last word.
        doReset("reset_c");
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("faultC_boot");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 0, 0, 32'h0);
            checkOutput("faultC_run");
        end
        checkValue("faultC_last_instr", bus.instruction_o, 32'h1000_003F);
        checkValue("faultC_last_valid", 32'(bus.valid_o), 32'd1);
        checkValue("faultC_last_fault", 32'(bus.fault_o), 32'd1);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("faultC_halt");
        checkValue("faultC_halt_valid", 32'(bus.valid_o), 32'd0);
        checkValue("faultC_halt_romaddr", bus.rom_address_o, 32'd63);

        // Randomized traffic against the model.
        doReset("reset_rand");
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2 || (mHalted && r < 30)) begin
                doReset("rand_reset");
            end else begin
                s = ($urandom_range(0, 3) == 0);
                f = ($urandom_range(0, 7) == 0);
                p = ($urandom_range(0, 11) == 0);
                case ($urandom_range(0, 5))
                    0, 1, 2: t = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                    3:       t = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                    4:       t = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
                    default: t = $urandom;
                endcase
                applyStimulus(s, f, p, t);
                checkOutput("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Fetch stage that owns the program counter and drives the word address of the combinational `Program_Memory` ROM.
- Captures the returned instruction into an IF/ID pipeline register with a valid bit.
- Handles stall, flush and branch/jump redirects from downstream stages.
- Raises a sticky fault and halts on misaligned or out-of-range fetch addresses.

## Interface
- TEXT_BASE, 32'h0040_0000, byte address of ROM word 0 (reset PC)
- MEMORY_DEPTH, 64, number of 32-bit words in the program ROM
- DATA_WIDTH, 32, instruction/address width
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; all state cleared immediately on reset==0
- stall_i  in  1  hold PC and IF/ID contents
- flush_i  in  1  replace IF/ID contents with a bubble
- pc_src_i  in  1  redirect: load PC from target_i
- target_i  in  DATA_WIDTH  redirect byte address
- rom_instruction_i  in  DATA_WIDTH  instruction returned by program memory (same cycle)
- rom_address_o  out  DATA_WIDTH  word index to program memory = (PC − TEXT_BASE) >> 2
- instruction_o  out  DATA_WIDTH  IF/ID instruction
- pc_o  out  DATA_WIDTH  byte address of instruction_o
- pc_plus4_o  out  DATA_WIDTH  pc_o + 4, registered
- valid_o  out  1  instruction_o is a real fetched instruction
- fault_o  out  1  sticky fetch fault; cleared only by reset

## Operation
- **State machine:** BOOT, RUN, HALT.
- **Reset values:**
  - State: BOOT; PC = TEXT_BASE; rom_address_o = 0.
  - instruction_o = NOP; pc_o = 0; pc_plus4_o = 0; valid_o = 0; fault_o = 0.
- **BOOT:**
  - Lasts exactly one cycle. PC is held and IF/ID stays a bubble.
  - Next state is RUN unconditionally; stall_i, flush_i and pc_src_i are ignored.
- **RUN:** evaluated at each rising edge, in priority order.
  1. pc_src_i=1 with a legal target_i:
     - PC ← target_i; IF/ID ← bubble (valid 0, NOP).
     - Overrides stall_i.
  2. pc_src_i=1 with an illegal target_i:
     - Illegal means target_i[1:0]≠0, target_i < TEXT_BASE, or target_i ≥ TEXT_BASE+4·MEMORY_DEPTH.
     - Go to HALT, fault_o ← 1, PC unchanged, IF/ID ← bubble.
  3. flush_i=1:
     - IF/ID ← bubble.
     - PC ← PC+4 unless stall_i=1, in which case PC holds.
  4. stall_i=1:
     - PC, instruction_o, pc_o, pc_plus4_o and valid_o all hold.
  5. Otherwise (normal fetch):
     - instruction_o ← rom_instruction_i; pc_o ← PC; pc_plus4_o ← PC+4; valid_o ← 1.
     - If PC+4 = TEXT_BASE+4·MEMORY_DEPTH: capture normally, then go to HALT with fault_o ← 1 and PC unchanged.
     - Else PC ← PC+4.
- **HALT:**
  - All inputs are ignored.
  - The cycle after entry: IF/ID ← bubble, then held.
  - PC and rom_address_o are frozen; fault_o = 1.
  - Exit only via reset.
- **Arithmetic:** all PC arithmetic is modulo 2^32. Out-of-range checks use unsigned compares. rom_address_o is combinational from the PC register only and never depends on inputs.

## Timing
- **Fetch latency:**
  - rom_address_o changes combinationally after each PC update.
  - The instruction is captured at the next rising edge: 1-cycle latency, one instruction per cycle when unstalled.
- **After reset deassertion:**
  - Edge 1: BOOT→RUN.
  - Edge 2: first capture; valid_o=1, pc_o=TEXT_BASE.
- **Redirect:**
  - target_i is sampled on the edge where pc_src_i=1; the next PC then equals target_i.
  - The target instruction appears on instruction_o one edge later.
  - Exactly one bubble (valid_o=0) appears between the last old-path instruction and the target instruction.
- **Stall:** outputs are bit-identical across every stalled cycle; stall deassertion resumes the fetch at the held PC.
- **Reset mid-operation:** outputs take their reset values immediately, without waiting for a clock edge. Operation restarts at BOOT.

## Test plan
- **Reset/boot:**
  - Stimulus: ROM word i = 0x1000_0000+i; release reset.
  - Required: edge 1 valid_o=0; edge 2 instruction_o=0x1000_0000, pc_o=0x0040_0000, pc_plus4_o=0x0040_0004; edge 3 instruction_o=0x1000_0001.
- **Stall:**
  - Stimulus: stall_i=1 for 3 cycles while pc_o=0x0040_0008.
  - Required: outputs unchanged for all 3 cycles; rom_address_o=3 held; next capture after release is 0x1000_0003.
- **Redirect with simultaneous stall:**
  - Stimulus: pc_src_i=1, stall_i=1, target_i=0x0040_0020.
  - Required: next edge valid_o=0 and instruction_o=NOP; rom_address_o=8; following edge instruction_o=0x1000_0008.
- **Flush:**
  - Stimulus: flush_i=1 for one cycle.
  - Required: valid_o=0 and instruction_o=0x0000_0013 for one cycle; the PC sequence continues by +4.
- **Faults:**
  - Stimulus A: target_i=0x0040_0002. Required A: fault_o=1, HALT, PC unchanged.
  - Stimulus B: target_i=0x0040_0100 with MEMORY_DEPTH=64. Required B: fault_o=1, HALT.
  - Stimulus C: sequential run to word 63. Required C: 0x1000_003F captured valid, then fault_o=1 and valid_o=0.
- **Reset mid-run:**
  - Stimulus: assert reset between clock edges while fault_o=1.
  - Required: fault_o=0, valid_o=0, rom_address_o=0 immediately; normal boot sequence follows.
